// File: rtl/msx_mapper_gen2.sv
// rtl/msx_mapper_gen2.sv - MSX cartridge mapper with bank translation and SDRAM handshake
// Optional define: MAPPER_READBACK_EN (I/O readback of bank registers at MRAM_PORT+1..+4)
module msx_mapper_gen2 #(
    parameter int                ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 23'h420000,
    parameter int                BANK_W    = 8,
    parameter logic [BANK_W-1:0] BANK_MASK = 8'hFF,
    parameter logic [7:0]        MRAM_PORT = 8'h8E,
    parameter int                TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       addr,
    input  logic [7:0]        cdin,
    output logic [7:0]        cdout,
    output logic              rd_data_valid,
    input  logic              sltsl_n,
    input  logic              merq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [1:0]        mapper_type,
    output logic              wait_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              ram_mode,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state;
    logic [BANK_W-1:0]  bank [4];
    logic               prev_wr_n;
    logic               prev_strb;
    logic               req_is_rd;
    logic [CNT_W-1:0]   cnt;

    logic               cart_sel;
    logic               io_port;
    logic               wr_fall;
    logic               strb_fall;
    logic [1:0]         page;
    logic               bw_en;
    logic [1:0]         bw_idx;
    logic               bank_we;
    logic [BANK_W+12:0] offset;
    logic [ADDR_W-1:0]  xlate;
    logic               start_req;

    assign cart_sel  = ~sltsl_n & ~merq_n & iorq_n & (addr[15:14] == 2'b01 || addr[15:14] == 2'b10);
    assign io_port   = ~iorq_n & m1_n & (addr[7:0] == MRAM_PORT);
    assign wr_fall   = prev_wr_n & ~wr_n;
    assign strb_fall = prev_strb & ~(rd_n & wr_n);
    // 8K page index relative to 4000h: 4000h->0, 6000h->1, 8000h->2, A000h->3
    assign page      = addr[14:13] ^ 2'b10;

    always_comb begin
        bw_en  = 1'b0;
        bw_idx = page;
        case (mapper_type)
            2'd0: bw_en = 1'b1;
            2'd1: bw_en = (addr[12:11] == 2'b10);
            2'd2: begin
                bw_idx = addr[12:11];
                bw_en  = (addr[15:13] == 3'b011);
            end
            default: begin
                bw_idx = {1'b0, addr[12]};
                bw_en  = (addr[15:11] == 5'b01100) || (addr[15:11] == 5'b01110);
            end
        endcase
    end

    assign bank_we = cart_sel & ~ram_mode & wr_fall & bw_en;

    always_comb begin
        offset = '0;
        if (mapper_type == 2'd3) begin
            if (addr[15])
                offset = {bank[1][BANK_W-2:0], addr[13:0]};
            else
                offset = {bank[0][BANK_W-2:0], addr[13:0]};
        end else begin
            offset = {bank[page], addr[12:0]};
        end
    end

    assign xlate     = BASE_ADDR + ADDR_W'(offset);
    assign start_req = cart_sel & strb_fall & (~rd_n | (~wr_n & ram_mode));

`ifdef MAPPER_READBACK_EN
    logic [7:0] rb_off;
    logic       rb_hit;
    assign rb_off = addr[7:0] - MRAM_PORT - 8'd1;
    assign rb_hit = ~iorq_n & m1_n & ~rd_n & (rb_off < 8'd4);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bank[0]       <= BANK_W'(0);
            bank[1]       <= BANK_W'(1);
            bank[2]       <= BANK_W'(2);
            bank[3]       <= BANK_W'(3);
            prev_wr_n     <= 1'b1;
            prev_strb     <= 1'b1;
            req_is_rd     <= 1'b0;
            cnt           <= '0;
            ram_mode      <= 1'b0;
            wait_n        <= 1'b1;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_wdata     <= 8'h00;
            cdout         <= 8'hFF;
            rd_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            prev_wr_n <= wr_n;
            prev_strb <= rd_n & wr_n;

            if (bank_we)
                bank[bw_idx] <= BANK_W'(cdin) & BANK_MASK;

            if (io_port & ~wr_n)
                ram_mode <= 1'b0;
            else if (io_port & ~rd_n)
                ram_mode <= 1'b1;

            case (state)
                IDLE: begin
                    rd_data_valid <= 1'b0;
`ifdef MAPPER_READBACK_EN
                    if (rb_hit) begin
                        cdout         <= 8'(bank[rb_off[1:0]]);
                        rd_data_valid <= 1'b1;
                    end
`endif
                    if (start_req) begin
                        state     <= REQ;
                        wait_n    <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= ~wr_n;
                        mem_addr  <= xlate;
                        mem_wdata <= cdin;
                        req_is_rd <= ~rd_n;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    // The SDRAM transaction always completes even if the Z80 drops its strobe
                    if (mem_ack || cnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        wait_n  <= 1'b1;
                        if (!mem_ack)
                            timeout_err <= 1'b1;
                        if (req_is_rd) begin
                            cdout         <= mem_ack ? mem_rdata : 8'hFF;
                            rd_data_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rd_n & wr_n) begin
                        state         <= IDLE;
                        rd_data_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
